// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, widths and pipeline-control patterns for hazard_ctrl.
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam int         PERF_CNT_W = 16;
   localparam logic [4:0] X0_ADDR    = 5'd0;

   // Bit order: {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id_flush, id_ex_flush}
   localparam logic [6:0] CTL_RUN    = 7'b1111100;
   localparam logic [6:0] CTL_FREEZE = 7'b0000000;
   localparam logic [6:0] CTL_FLUSH  = 7'b1111111;
   localparam logic [6:0] CTL_BUBBLE = 7'b0011101;
endpackage

// File: rtl/hazard_sat_cnt.sv
// hazard_sat_cnt: saturating up-counter with enable and asynchronous active-low clear.
module hazard_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) cnt_q <= '0;
      else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;

   assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and data-memory wait control with timeout watchdog.
// Performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MAX_MEM_WAIT = 64,
   parameter int WAIT_CNT_W   = 7
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [4:0]            rs1_id,
   input  logic [4:0]            rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [4:0]            rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  branch_taken_ex,
   input  logic                  mem_req_mem,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  mem_wb_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  mem_timeout,
   output logic [PERF_CNT_W-1:0] stall_cycles,
   output logic [PERF_CNT_W-1:0] flush_count,
   output logic [PERF_CNT_W-1:0] mem_wait_cycles
);
   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  timeout_q, timeout_d;
   logic                  lu, mw;
   logic [6:0]            ctl;

   assign lu = mem_read_ex && rd_ex != X0_ADDR &&
               ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
   assign mw = mem_req_mem && !dmem_ready;

   // A frozen pipeline keeps branch/lu inputs stable, so release reuses the RUN decision.
   always_comb begin
      ctl        = CTL_RUN;
      state_d    = RUN;
      wait_cnt_d = '0;
      timeout_d  = timeout_q | (state_q == MEM_WAIT && wait_cnt_q >= WAIT_CNT_W'(MAX_MEM_WAIT));
      if (mw) begin
         ctl        = CTL_FREEZE;
         state_d    = MEM_WAIT;
         wait_cnt_d = state_q != MEM_WAIT ? WAIT_CNT_W'(1) :
                      &wait_cnt_q ? wait_cnt_q : wait_cnt_q + 1'b1;
      end else if (branch_taken_ex) begin
         ctl = CTL_FLUSH;
      end else if (lu && state_q != LU_STALL) begin
         ctl     = CTL_BUBBLE;
         state_d = LU_STALL;
      end
   end

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end

   assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush} = arst_n ? ctl : CTL_FREEZE;
   assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
   hazard_sat_cnt #(.W(PERF_CNT_W)) u_stall_cnt (
      .clk(clk), .arst_n(arst_n), .en_i(!pc_write), .cnt_o(stall_cycles));
   hazard_sat_cnt #(.W(PERF_CNT_W)) u_flush_cnt (
      .clk(clk), .arst_n(arst_n), .en_i(if_id_flush), .cnt_o(flush_count));
   hazard_sat_cnt #(.W(PERF_CNT_W)) u_wait_cnt (
      .clk(clk), .arst_n(arst_n), .en_i(state_q == MEM_WAIT), .cnt_o(mem_wait_cycles));
`else
   assign stall_cycles    = '0;
   assign flush_count     = '0;
   assign mem_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against a cycle-level behavioural model of hazard_ctrl.
module tb_hazard_ctrl;
   logic        clk = 1'b0, arst_n = 1'b0;
   logic [4:0]  rs1_id, rs2_id, rd_ex;
   logic        rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, mem_req_mem, dmem_ready;
   logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic        if_id_flush, id_ex_flush, mem_timeout;
   logic [15:0] stall_cycles, flush_count, mem_wait_cycles;
   int          checks = 0, errors = 0;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   // Model: was the last cycle frozen, was it a load-use bubble, how long the current freeze has run.
   bit in_wait, after_bubble, timeout;
   int wait_seen, n_stall, n_flush, n_wait;

   hazard_ctrl dut (
      .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
      .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
      .mem_req_mem(mem_req_mem), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
      .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_wait_cycles(mem_wait_cycles));

   always #5 clk = ~clk;

   function automatic logic [6:0] ctl_out();
      return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, if_id_flush, id_ex_flush};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [4:0] r1, r2, rd, input logic u1, u2, mrd, br, mreq, rdy);
      rs1_id = r1; rs2_id = r2; rd_ex = rd; rs1_used_id = u1; rs2_used_id = u2;
      mem_read_ex = mrd; branch_taken_ex = br; mem_req_mem = mreq; dmem_ready = rdy;
   endtask

   task automatic check_counters();
      check("stall_cycles", stall_cycles, PERF ? n_stall : 0);
      check("flush_count", flush_count, PERF ? n_flush : 0);
      check("mem_wait_cycles", mem_wait_cycles, PERF ? n_wait : 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      arst_n = 1'b0;
      #1;
      in_wait = 0; after_bubble = 0; timeout = 0;
      wait_seen = 0; n_stall = 0; n_flush = 0; n_wait = 0;
      check("rst_ctl", ctl_out(), 7'b0);
      check("rst_timeout", mem_timeout, timeout);
      check_counters();
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   task automatic cyc(input logic [4:0] r1, r2, rd, input logic u1, u2, mrd, br, mreq, rdy);
      logic       mw, lu;
      logic [6:0] exp;
      @(negedge clk);
      drive(r1, r2, rd, u1, u2, mrd, br, mreq, rdy);
      #1;
      mw  = mreq && !rdy;
      lu  = mrd && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
      exp = mw ? 7'b0000000 : br ? 7'b1111111 : (lu && !after_bubble) ? 7'b0011101 : 7'b1111100;
      check("ctl", ctl_out(), exp);
      check("timeout", mem_timeout, timeout);
      check_counters();
      if (in_wait && wait_seen >= 64) timeout = 1;
      if (!exp[6] && n_stall < 65535) n_stall++;
      if (exp[1] && n_flush < 65535) n_flush++;
      if (in_wait && n_wait < 65535) n_wait++;
      after_bubble = !mw && !br && lu && !after_bubble;
      wait_seen    = mw ? wait_seen + 1 : 0;
      in_wait      = mw;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("init_rst_ctl", ctl_out(), 7'b0);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(5, 0, 5, 1, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc(0, 7, 0, 0, 1, 1, 0, 0, 0);
      cyc(5, 0, 5, 1, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(3, 9, 9, 0, 1, 1, 0, 0, 0);
      cyc(3, 9, 9, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 70; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(4, 0, 4, 1, 0, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 4) == 0, in_wait || $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) < (i % 200 < 100 ? 5 : 1));
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the forwarding unit and handles the cases forwarding cannot resolve:
- load-use stalls
- taken-branch flushes
- data-memory wait states

It drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, using a small FSM plus a wait-cycle watchdog.

Parameters:
MAX_MEM_WAIT, 64, wait cycles in MEM_WAIT before mem_timeout is raised
WAIT_CNT_W, 7, width of the wait counter; must hold MAX_MEM_WAIT

Ports:
clk  in  1  core clock, rising edge
arst_n  in  1  asynchronous active-low reset
rs1_id  in  5  rs1 of instruction in ID
rs2_id  in  5  rs2 of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  5  destination of instruction in EX
mem_read_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  branch/jump resolved taken in EX
mem_req_mem  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
id_ex_write  out  1  ID/EX register enable
ex_mem_write  out  1  EX/MEM register enable
mem_wb_write  out  1  MEM/WB register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  clear ID/EX to bubble
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  16  perf counter (see Optional Feature)
flush_count  out  16  perf counter
mem_wait_cycles  out  16  perf counter

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=RUN, wait_cnt=0, mem_timeout=0, perf counters 0.
  - While reset is asserted: all *_write=0, all flushes=0.
- Outputs are combinational from state and current inputs (zero latency). State and counters update on the rising clk edge.
- Load-use condition lu:
  - mem_read_ex && rd_ex!=0
  - && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
- Memory-wait condition mw: mem_req_mem && !dmem_ready.
- Priority: mw > branch_taken_ex > lu.
- States: RUN, LU_STALL, MEM_WAIT.
- RUN:
  - mw: all five writes=0, no flush; next=MEM_WAIT, wait_cnt<=1.
  - else branch_taken_ex: all writes=1, if_id_flush=1, id_ex_flush=1; next=RUN. A simultaneous lu is discarded because ID holds a wrong-path instruction.
  - else lu: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1; next=LU_STALL.
  - else: all writes=1, no flush.
- LU_STALL (one cycle; the load is now in MEM):
  - Evaluate exactly as RUN, except lu is ignored, so no back-to-back bubble for the same load.
  - Next=MEM_WAIT if mw, else RUN.
- MEM_WAIT:
  - All writes=0, no flushes. The pipeline is frozen, so branch_taken_ex stays stable and is honoured on release.
  - While mw: wait_cnt increments, saturating at all-ones.
  - When wait_cnt==MAX_MEM_WAIT, set mem_timeout=1. It stays set until reset, and the FSM keeps waiting.
  - On dmem_ready:
    - Release this cycle: outputs as RUN with mw=0 (branch or lu handling applies), next=RUN or LU_STALL, wait_cnt<=0.
- rd_ex==0 never causes a stall.
- mem_req_mem with dmem_ready=1 in the same cycle costs no stall.

Optional Feature:
HAZARD_PERF_EN.
- Defined:
  - stall_cycles counts cycles with pc_write=0 and arst_n high.
  - flush_count counts cycles with if_id_flush=1.
  - mem_wait_cycles counts cycles in MEM_WAIT.
  - All 16-bit, saturating at 16'hFFFF, cleared by reset.
- Undefined: counters are not instantiated and the three ports are tied to 16'h0.

Decomposition:
- Package hazard_pkg: state encoding (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2), PERF_CNT_W=16, X0_ADDR=5'd0.
- One sub-module: hazard_sat_cnt, a saturating counter with enable and async active-low clear, instantiated three times under HAZARD_PERF_EN.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle with lu gone, all writes=1, state RUN.
- rd_ex=0 with mem_read_ex=1, rs1_id=0, rs1_used_id=1 -> no stall; all writes=1.
- branch_taken_ex=1 together with the lu condition -> if_id_flush=1, id_ex_flush=1, pc_write=1; no LU_STALL entry.
- mem_req_mem=1, dmem_ready=0 for 3 cycles then 1 -> all writes=0 for 3 cycles, release on cycle 4; mem_wait_cycles=3 with HAZARD_PERF_EN.
- dmem_ready held 0 for 70 cycles (MAX_MEM_WAIT=64) -> mem_timeout rises when wait_cnt reaches 64 and stays 1 after release until arst_n pulses low.
- arst_n asserted mid-MEM_WAIT -> outputs immediately all writes=0, flushes=0; after deassertion state=RUN, mem_timeout=0, counters 0.
